// File: rtl/aes_sched_pkg.sv
// Shared types and widths for the AES-128 core scheduler.
package aes_sched_pkg;

    localparam int unsigned HALF_W       = 64;
    localparam int unsigned BLK_W        = 128;
    localparam int unsigned CORE_LAT_MAX = 63;
    localparam int unsigned CNT_W        = $clog2(CORE_LAT_MAX + 1);

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        WAIT,
        CAP_HI,
        CAP_LO,
        RESP
    } state_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser after every accept.
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = '0;
        if (req[0] && req[1]) begin
            gnt[ptr] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/aes_core_sched.sv
// Arbitrates two clients onto one AES-128 core: two load beats, fixed-latency wait,
// two capture beats, then a held response to the owning client.
module aes_core_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned CORE_LAT = 11
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_mode,
    input  logic [BLK_W-1:0]  req_data0,
    input  logic [BLK_W-1:0]  req_data1,
    input  logic [BLK_W-1:0]  req_key0,
    input  logic [BLK_W-1:0]  req_key1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [BLK_W-1:0]  rsp_text,
    output logic [BLK_W-1:0]  rsp_key10,
    output logic              core_start,
    output logic              core_select,
    output logic [HALF_W-1:0] core_data,
    output logic [HALF_W-1:0] core_key,
    input  logic [HALF_W-1:0] core_text,
    input  logic [HALF_W-1:0] core_key10,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CORE_LAT - 1);

    state_t             state, state_nxt;
    logic [1:0]         gnt;
    logic               accept;
    logic               owner;
    logic               sel_q;
    logic [CNT_W-1:0]   cnt;
    logic [BLK_W-1:0]   blk_data, blk_key;
    logic [BLK_W-1:0]   res_text, res_key10;

    assign accept = (state == IDLE) && (gnt != '0);

    aes_rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (reset),
        .req    (req_valid),
        .accept (accept),
        .gnt    (gnt)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the number of cycles since LOAD_HI; a short latency skips WAIT entirely
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = LOAD_HI;
            LOAD_HI: state_nxt = LOAD_LO;
            LOAD_LO: state_nxt = (cnt == LAT_LAST) ? CAP_HI : WAIT;
            WAIT:    if (cnt == LAT_LAST) state_nxt = CAP_HI;
            CAP_HI:  state_nxt = CAP_LO;
            CAP_LO:  state_nxt = RESP;
            RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
        core_data  = '0;
        core_key   = '0;
        unique case (state)
            IDLE: req_ready = gnt;
            LOAD_HI: begin
                core_start = 1'b1;
                core_data  = blk_data[BLK_W-1:HALF_W];
                core_key   = blk_key[BLK_W-1:HALF_W];
            end
            LOAD_LO: begin
                core_data = blk_data[HALF_W-1:0];
                core_key  = blk_key[HALF_W-1:0];
            end
            RESP: rsp_valid[owner] = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state != IDLE);
    assign core_select = sel_q;
    assign rsp_text    = res_text;
    assign rsp_key10   = res_key10;

    // sel_q loads on accept so Select changes exactly at LOAD_HI and holds until the next job
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            owner     <= 1'b0;
            sel_q     <= MODE_ENC;
            cnt       <= '0;
            blk_data  <= '0;
            blk_key   <= '0;
            res_text  <= '0;
            res_key10 <= '0;
        end else begin
            if (accept) begin
                owner    <= gnt[1];
                sel_q    <= req_mode[gnt[1]];
                blk_data <= gnt[1] ? req_data1 : req_data0;
                blk_key  <= gnt[1] ? req_key1  : req_key0;
            end
            if (state == LOAD_HI) begin
                cnt <= CNT_W'(1);
            end else if (state == LOAD_LO || state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == CAP_HI) begin
                res_text[BLK_W-1:HALF_W]  <= core_text;
                res_key10[BLK_W-1:HALF_W] <= core_key10;
            end
            if (state == CAP_LO) begin
                res_text[HALF_W-1:0]  <= core_text;
                res_key10[HALF_W-1:0] <= core_key10;
            end
        end
    end

endmodule

// File: tb/tb_aes_core_sched.sv
// Scoreboard bench for aes_core_sched: one instance at the default latency, one at CORE_LAT=2,
// each driving a behavioural core that only returns valid data in the exact capture cycles.
module tb_aes_core_sched;
    import aes_sched_pkg::*;

    localparam logic [127:0] V_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam int unsigned LAT0 = 11;
    localparam int unsigned LAT1 = 2;

    typedef struct {
        logic        own;
        logic [255:0] res;
        int unsigned t;
    } exp_t;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int errs  = 0;

    logic [1:0][1:0]   req_valid_a, req_mode_a, rsp_ready_a;
    logic [1:0][127:0] data0_a, data1_a, key0_a, key1_a;
    int unsigned       acc_cnt [2] = '{0, 0};
    int unsigned       done_cnt [2] = '{0, 0};
    logic [255:0]      last_res [2];
    int unsigned       acc_cyc_q[$];
    logic              acc_own_q[$];
    int unsigned       hs_cyc = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stand-in for the AES core: known vectors map to their true results, anything else to a fixed mix.
    function automatic logic [255:0] core_fn(input logic [127:0] d, input logic [127:0] k, input logic m);
        if (m == MODE_ENC && d == V_PT && k == V_K)   return {V_CT, V_K10};
        if (m == MODE_DEC && d == V_CT && k == V_K10) return {V_PT, V_K};
        return {d ^ {k[63:0], k[127:64]} ^ {128{m}}, ~k};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int unsigned LAT = (g == 0) ? LAT0 : LAT1;

        logic [1:0]   req_ready, rsp_valid;
        logic [127:0] rsp_text, rsp_key10;
        logic         core_start, core_select, busy;
        logic [63:0]  core_data, core_key, core_text, core_key10;

        aes_core_sched #(.CORE_LAT(LAT)) dut (
            .CLK         (CLK),
            .reset       (reset),
            .req_valid   (req_valid_a[g]),
            .req_ready   (req_ready),
            .req_mode    (req_mode_a[g]),
            .req_data0   (data0_a[g]),
            .req_data1   (data1_a[g]),
            .req_key0    (key0_a[g]),
            .req_key1    (key1_a[g]),
            .rsp_valid   (rsp_valid),
            .rsp_ready   (rsp_ready_a[g]),
            .rsp_text    (rsp_text),
            .rsp_key10   (rsp_key10),
            .core_start  (core_start),
            .core_select (core_select),
            .core_data   (core_data),
            .core_key    (core_key),
            .core_text   (core_text),
            .core_key10  (core_key10),
            .busy        (busy)
        );

        logic         m_act = 1'b0;
        int unsigned  m_st = 0;
        logic [63:0]  m_dh = '0, m_kh = '0;
        logic         m_sel = 1'b0;
        logic [255:0] m_res = '0;

        always @(negedge CLK) begin
            if (!reset) begin
                m_act = 1'b0;
            end else if (core_start) begin
                m_act = 1'b1;
                m_st  = cyc;
                m_dh  = core_data;
                m_kh  = core_key;
                m_sel = core_select;
            end else if (m_act && cyc == m_st + 1) begin
                m_res = core_fn({m_dh, core_data}, {m_kh, core_key}, m_sel);
            end
        end

        always_comb begin
            core_text  = 64'hbad0bad0bad0bad0;
            core_key10 = 64'hdeaddeaddeaddead;
            if (m_act && cyc == m_st + LAT) begin
                core_text  = m_res[255:192];
                core_key10 = m_res[127:64];
            end else if (m_act && cyc == m_st + LAT + 1) begin
                core_text  = m_res[191:128];
                core_key10 = m_res[63:0];
            end
        end

        exp_t         sb[$];
        logic         has_acc = 1'b0;
        int unsigned  last_acc = 0;
        logic [127:0] last_d = '0, last_k = '0;
        logic         last_m = 1'b0;
        logic         rv_prev = 1'b0;

        always @(negedge CLK) begin
            exp_t       e;
            logic [1:0] acc;
            if (!reset) begin
                sb.delete();
                has_acc = 1'b0;
                rv_prev = 1'b0;
            end else begin
                acc = req_valid_a[g] & req_ready;
                if (acc != 2'b00) begin
                    check("acc_onehot", $onehot(acc), 1);
                    last_d = acc[1] ? data1_a[g] : data0_a[g];
                    last_k = acc[1] ? key1_a[g] : key0_a[g];
                    last_m = req_mode_a[g][acc[1]];
                    e.own = acc[1];
                    e.res = core_fn(last_d, last_k, last_m);
                    e.t   = cyc;
                    sb.push_back(e);
                    has_acc  = 1'b1;
                    last_acc = cyc;
                    acc_cnt[g]++;
                    if (g == 0) begin
                        acc_cyc_q.push_back(cyc);
                        acc_own_q.push_back(acc[1]);
                    end
                end
                if (has_acc && cyc == last_acc + 1) begin
                    check("start_hi", core_start, 1);
                    check("beat_hi", {core_data, core_key}, {last_d[127:64], last_k[127:64]});
                    check("sel_hi", core_select, last_m);
                end
                if (has_acc && cyc == last_acc + 2) begin
                    check("start_lo", core_start, 0);
                    check("beat_lo", {core_data, core_key}, {last_d[63:0], last_k[63:0]});
                    check("sel_lo", core_select, last_m);
                end
                if (rsp_valid != 2'b00) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = sb[0];
                        if (!rv_prev) check("rsp_time", cyc, e.t + LAT + 3);
                        check("rsp_valid", rsp_valid, e.own ? 2'b10 : 2'b01);
                        check("rsp_bus", {rsp_text, rsp_key10}, e.res);
                        if (rsp_ready_a[g][e.own]) begin
                            void'(sb.pop_front());
                            last_res[g] = {rsp_text, rsp_key10};
                            done_cnt[g]++;
                            if (g == 0) hs_cyc = cyc;
                        end
                    end
                end
                rv_prev = (rsp_valid != 2'b00);
            end
        end
    end

    task automatic wait_acc(input int inst, input int unsigned target, input string tag);
        int unsigned n = 0;
        while (acc_cnt[inst] < target && n < 200) begin
            @(posedge CLK);
            n++;
        end
        check(tag, acc_cnt[inst] >= target, 1);
    endtask

    task automatic wait_done(input int inst, input int unsigned target, input string tag);
        int unsigned n = 0;
        while (done_cnt[inst] < target && n < 200) begin
            @(posedge CLK);
            n++;
        end
        check(tag, done_cnt[inst] >= target, 1);
    endtask

    task automatic send(input int inst, input int who, input logic m,
                        input logic [127:0] d, input logic [127:0] k);
        int unsigned target = acc_cnt[inst] + 1;
        @(posedge CLK);
        #1;
        if (who == 0) begin
            data0_a[inst] = d;
            key0_a[inst]  = k;
        end else begin
            data1_a[inst] = d;
            key1_a[inst]  = k;
        end
        req_mode_a[inst][who]  = m;
        req_valid_a[inst][who] = 1'b1;
        wait_acc(inst, target, "acc_timeout");
        #1 req_valid_a[inst][who] = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int unsigned base;
        int unsigned dbase;
        int unsigned n;
        req_valid_a = '0;
        req_mode_a  = '0;
        rsp_ready_a = '1;
        data0_a = '0;
        data1_a = '0;
        key0_a  = '0;
        key1_a  = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ctrl", {gi[0].req_ready, gi[0].rsp_valid, gi[0].busy,
                           gi[0].core_start, gi[0].core_select}, 0);
        check("rst_bus", {gi[0].rsp_text, gi[0].rsp_key10}, 0);
        check("rst_core", {gi[0].core_data, gi[0].core_key}, 0);
        reset = 1'b1;

        // requester 0 encrypt, known vector
        send(0, 0, MODE_ENC, V_PT, V_K);
        wait_done(0, 1, "enc_done");
        check("enc_result", last_res[0], {V_CT, V_K10});

        // requester 1 decrypt, known vector
        send(0, 1, MODE_DEC, V_CT, V_K10);
        wait_done(0, 2, "dec_done");
        check("dec_text", last_res[0][255:128], V_PT);

        // both requesters continuously valid: strict alternation at minimum spacing
        acc_cyc_q.delete();
        acc_own_q.delete();
        @(posedge CLK);
        #1;
        data0_a[0] = rnd128();
        data1_a[0] = rnd128();
        key0_a[0]  = rnd128();
        key1_a[0]  = rnd128();
        req_mode_a[0] = 2'($urandom_range(0, 3));
        base  = acc_cnt[0];
        dbase = done_cnt[0];
        req_valid_a[0] = 2'b11;
        wait_acc(0, base + 4, "alt_acc");
        #1 req_valid_a[0] = 2'b00;
        wait_done(0, dbase + 4, "alt_done");
        check("alt_count", acc_own_q.size(), 4);
        for (int i = 0; i < acc_own_q.size(); i++) begin
            check("alt_owner", acc_own_q[i], i % 2);
            if (i > 0) check("alt_space", acc_cyc_q[i] - acc_cyc_q[i-1], LAT0 + 4);
        end

        // response held off for 20 cycles while requester 1 waits; non-owner ready is ignored
        @(posedge CLK);
        #1;
        rsp_ready_a[0] = 2'b10;
        data0_a[0] = V_PT;
        key0_a[0]  = V_K;
        data1_a[0] = rnd128();
        key1_a[0]  = rnd128();
        req_mode_a[0] = 2'b00;
        base  = acc_cnt[0];
        dbase = done_cnt[0];
        req_valid_a[0] = 2'b11;
        wait_acc(0, base + 1, "hold_acc");
        #1 req_valid_a[0] = 2'b10;
        n = 0;
        while (gi[0].rsp_valid == 2'b00 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("hold_ready", gi[0].req_ready, 0);
            check("hold_valid", gi[0].rsp_valid, 2'b01);
        end
        @(posedge CLK);
        #1 rsp_ready_a[0] = 2'b11;
        wait_acc(0, base + 2, "hold_next_acc");
        #1 req_valid_a[0] = 2'b00;
        check("hold_result", last_res[0], {V_CT, V_K10});
        check("hold_next_cycle", acc_cyc_q[$], hs_cyc + 1);
        wait_done(0, dbase + 2, "hold_done");

        // reset during WAIT aborts the job and returns the pointer to requester 0
        send(0, 0, MODE_DEC, rnd128(), rnd128());
        dbase = done_cnt[0];
        repeat (4) @(posedge CLK);
        #2 reset = 1'b0;
        #1;
        check("abort_ctrl", {gi[0].req_ready, gi[0].rsp_valid, gi[0].busy,
                             gi[0].core_start, gi[0].core_select}, 0);
        check("abort_bus", {gi[0].rsp_text, gi[0].rsp_key10}, 0);
        check("abort_core", {gi[0].core_data, gi[0].core_key}, 0);
        repeat (2) @(posedge CLK);
        #3 reset = 1'b1;
        @(posedge CLK);
        #1;
        data0_a[0] = rnd128();
        data1_a[0] = rnd128();
        base = acc_cnt[0];
        req_valid_a[0] = 2'b11;
        wait_acc(0, base + 1, "post_rst_acc");
        #1 req_valid_a[0] = 2'b00;
        check("post_rst_owner", acc_own_q[$], 0);
        wait_done(0, dbase + 1, "post_rst_done");
        check("post_rst_count", done_cnt[0], dbase + 1);

        // short-latency instance: capture at t+3/t+4, response at t+5
        send(1, 0, MODE_ENC, V_PT, V_K);
        wait_done(1, 1, "lat2_done");
        check("lat2_result", last_res[1], {V_CT, V_K10});
        send(1, 1, MODE_DEC, rnd128(), rnd128());
        wait_done(1, 2, "lat2_done_b");

        repeat (4) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
